// File: rtl/csr_file_pkg.sv
// csr_file_pkg: CSR addresses, access opcodes, mstatus layout and the read-modify-write helper.
package csr_file_pkg;
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam logic [31:0] MSTATUS_RST = 32'h0000_1800;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_RW   = 2'b01,
        OP_RS   = 2'b10,
        OP_RC   = 2'b11
    } csr_op_e;

    function automatic logic [31:0] csr_apply(input csr_op_e op, input logic [31:0] old, input logic [31:0] src);
        return op == OP_RW ? src : op == OP_RS ? (old | src) : op == OP_RC ? (old & ~src) : old;
    endfunction
endpackage

// File: rtl/csr_counter64.sv
// csr_counter64: 64-bit free-running counter whose halves can be overwritten independently.
module csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] count
);
    // A write to either half replaces it and suppresses the increment with no carry.
    always_ff @(posedge clk) begin
        if (rst)
            count <= 64'd0;
        else if (wr_lo || wr_hi)
            count <= {wr_hi ? wdata : count[63:32], wr_lo ? wdata : count[31:0]};
        else if (inc)
            count <= count + 64'd1;
    end
endmodule

// File: rtl/csr_file.sv
// csr_file: machine-mode CSR file with CSRRW/RS/RC(I) access, cycle/instret counters, trap entry and mret.
module csr_file
    import csr_file_pkg::*;
#(
    parameter logic [31:0] HART_ID  = 32'd0,
    parameter logic [31:0] MISA_VAL = 32'h4000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csr_w,
    input  logic        csr_data_s,
    input  logic [2:0]  f3,
    input  logic [11:0] csr_addr,
    input  logic [31:0] rs1_data,
    input  logic [4:0]  zimm,
    input  logic        instr_ret,
    input  logic        trap,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_cause,
    input  logic        mret,
    output logic [31:0] csr_rdata,
    output logic        illegal_csr,
    output logic [31:0] trap_vector,
    output logic [31:0] mepc_out,
    output logic        mie
);
    logic [31:0] mtvec, mscratch, mepc, mcause, src, wdata, mstatus;
    logic [63:0] mcycle, minstret;
    logic        mpie, mapped, wr_req, we;
    logic        unused_f3;
    csr_op_e     op;

    assign unused_f3 = f3[2];
    assign op = csr_op_e'(f3[1:0]);
    assign mstatus = {19'b0, 2'b11, 3'b0, mpie, 3'b0, mie, 3'b0};

    always_comb begin
        mapped = 1'b1;
        csr_rdata = 32'd0;
        case (csr_addr)
            CSR_MSTATUS:              csr_rdata = mstatus;
            CSR_MISA:                 csr_rdata = MISA_VAL;
            CSR_MTVEC:                csr_rdata = mtvec;
            CSR_MSCRATCH:             csr_rdata = mscratch;
            CSR_MEPC:                 csr_rdata = mepc;
            CSR_MCAUSE:               csr_rdata = mcause;
            CSR_MCYCLE, CSR_CYCLE:    csr_rdata = mcycle[31:0];
            CSR_MCYCLEH, CSR_CYCLEH:  csr_rdata = mcycle[63:32];
            CSR_MINSTRET, CSR_INSTRET:   csr_rdata = minstret[31:0];
            CSR_MINSTRETH, CSR_INSTRETH: csr_rdata = minstret[63:32];
            CSR_MHARTID:              csr_rdata = HART_ID;
            default:                  mapped = 1'b0;
        endcase
    end

    // Set/clear with a zero rs1 index or immediate is a pure read.
    assign wr_req = op == OP_RW || (op != OP_NONE && zimm != 5'd0);
    assign illegal_csr = csr_w && (!mapped || (csr_addr[11:10] == 2'b11 && wr_req));
    assign we = csr_w && wr_req && !illegal_csr && !trap;
    assign src = csr_data_s ? {27'b0, zimm} : rs1_data;
    assign wdata = csr_apply(op, csr_rdata, src);

    assign trap_vector = {mtvec[31:2], 2'b00};
    assign mepc_out = mepc;

    csr_counter64 u_mcycle (
        .clk   (clk),
        .rst   (rst),
        .inc   (1'b1),
        .wr_lo (we && csr_addr == CSR_MCYCLE),
        .wr_hi (we && csr_addr == CSR_MCYCLEH),
        .wdata (wdata),
        .count (mcycle)
    );

    csr_counter64 u_minstret (
        .clk   (clk),
        .rst   (rst),
        .inc   (instr_ret),
        .wr_lo (we && csr_addr == CSR_MINSTRET),
        .wr_hi (we && csr_addr == CSR_MINSTRETH),
        .wdata (wdata),
        .count (minstret)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            mie      <= MSTATUS_RST[MSTATUS_MIE];
            mpie     <= MSTATUS_RST[MSTATUS_MPIE];
            mtvec    <= 32'd0;
            mscratch <= 32'd0;
            mepc     <= 32'd0;
            mcause   <= 32'd0;
        end else if (trap) begin
            mepc   <= trap_pc & ~32'h3;
            mcause <= trap_cause;
            mpie   <= mie;
            mie    <= 1'b0;
        end else begin
            // mret owns mstatus this cycle; other CSR writes still land.
            if (mret) begin
                mie  <= mpie;
                mpie <= 1'b1;
            end else if (we && csr_addr == CSR_MSTATUS) begin
                mie  <= wdata[MSTATUS_MIE];
                mpie <= wdata[MSTATUS_MPIE];
            end
            if (we) begin
                case (csr_addr)
                    CSR_MTVEC:    mtvec    <= wdata & ~32'h3;
                    CSR_MSCRATCH: mscratch <= wdata;
                    CSR_MEPC:     mepc     <= wdata & ~32'h3;
                    CSR_MCAUSE:   mcause   <= wdata;
                    default:      ;
                endcase
            end
        end
    end
endmodule
